// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg: shared state encodings and byte-enable constants for the data-memory responder
package dm_resp_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
endpackage

// File: rtl/dm_byte_ram.sv
// dm_byte_ram: word array with synchronous byte-lane write and combinational read
module dm_byte_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/dm_wait_responder.sv
// dm_wait_responder: M-stage data-memory target that inserts LATENCY wait cycles per request
module dm_wait_responder
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam logic [3:0] LAT_M1 = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_check
    $error("dm_wait_responder: LATENCY must be in 0..15");
  end
  state_t      state;
  logic [3:0]  cnt;
  logic        l_wr;
  logic [31:2] l_addr;
  logic [3:0]  l_be;
  logic [31:0] l_wdata;
  logic        idle, to_resp, cur_wr, cur_err, we;
  logic [31:2] cur_addr;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata, ram_rdata;
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign idle = state == ST_IDLE;
  // In IDLE the port is used directly so a zero-latency request can write on its accept edge
  assign cur_wr    = idle ? req_wr         : l_wr;
  assign cur_addr  = idle ? req_addr[31:2] : l_addr;
  assign cur_be    = idle ? req_be         : l_be;
  assign cur_wdata = idle ? req_wdata      : l_wdata;
  assign cur_err   = (cur_addr >> DEPTH_LOG2) != '0;
  assign to_resp   = (idle && req_valid && LATENCY == 0) || (state == ST_WAIT && cnt == 4'd0);
  assign we        = to_resp && cur_wr && !cur_err;
  dm_byte_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (we),
    .be    (cur_be),
    .idx   (cur_addr[DEPTH_LOG2+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      l_wr       <= 1'b0;
      l_addr     <= '0;
      l_be       <= '0;
      l_wdata    <= '0;
    end else begin
      resp_valid <= to_resp;
      resp_err   <= to_resp && cur_err;
      resp_rdata <= (to_resp && !cur_wr && !cur_err) ? ram_rdata : '0;
      if (idle && req_valid) begin
        l_wr      <= req_wr;
        l_addr    <= req_addr[31:2];
        l_be      <= req_be;
        l_wdata   <= req_wdata;
        cnt       <= LAT_M1;
        state     <= LATENCY == 0 ? ST_RESP : ST_WAIT;
        req_ready <= 1'b0;
        busy      <= 1'b1;
      end else if (state == ST_WAIT) begin
        cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        state <= cnt == 4'd0 ? ST_RESP : ST_WAIT;
      end else if (state == ST_RESP) begin
        state     <= ST_IDLE;
        req_ready <= 1'b1;
        busy      <= 1'b0;
      end
    end
endmodule

// File: tb/tb_dm_wait_responder.sv
// tb_dm_wait_responder: directed bench for LATENCY=2 and LATENCY=0 responders against a transaction-level model
module tb_dm_wait_responder;
  import dm_resp_pkg::*;
  logic        clk = 0, reset = 0, req_valid = 0, req_wr = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        rdy[2], bsy[2], rv[2], re[2];
  logic [31:0] rd[2];
  int          checks = 0, errors = 0;
  bit          started = 0;
  always #5 clk = ~clk;
  dm_wait_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .resp_valid(rv[0]),
    .resp_rdata(rd[0]), .resp_err(re[0]), .busy(bsy[0]));
  dm_wait_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .resp_valid(rv[1]),
    .resp_rdata(rd[1]), .resp_err(re[1]), .busy(bsy[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  function automatic int lat(input int i);
    return i == 0 ? 2 : 0;
  endfunction
  // Model: a request accepted in cycle a takes effect (write or read) at the end of cycle a+L,
  // its response is visible in cycle a+L+1, and the responder is free again from cycle a+L+2.
  int          cyc = 0;
  int          free_c[2] = '{0, 0};
  int          res_c[2] = '{-1, -1};
  int          cmp_c[2];
  bit          act[2] = '{0, 0};
  logic        lwr[2];
  logic [31:0] la[2], lwd[2];
  logic [3:0]  lbe[2];
  logic [31:0] exp_rd[2];
  logic        exp_er[2];
  logic [31:0] mm[int];
  int          key;
  bit          bad;
  logic [31:0] w;
  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0;
        free_c[i] = 0;
        res_c[i] = -1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cyc >= free_c[i] && req_valid) begin
          act[i] = 1;
          lwr[i] = req_wr;
          la[i] = req_addr;
          lbe[i] = req_be;
          lwd[i] = req_wdata;
          cmp_c[i] = cyc + lat(i);
          free_c[i] = cyc + lat(i) + 2;
        end
        if (act[i] && cyc == cmp_c[i]) begin
          key = i * 4096 + int'(la[i][11:2]);
          bad = la[i][31:12] != 0;
          w = mm.exists(key) ? mm[key] : 32'h0;
          if (!bad && lwr[i]) begin
            for (int b = 0; b < 4; b++)
              if (lbe[i][b]) w[8*b +: 8] = lwd[i][8*b +: 8];
            mm[key] = w;
          end
          exp_rd[i] = (bad || lwr[i]) ? 32'h0 : w;
          exp_er[i] = bad;
          res_c[i] = cyc + 1;
          act[i] = 0;
        end
      end
      cyc++;
    end
  always @(negedge clk)
    if (started && !reset)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(cyc >= free_c[i]));
        chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(cyc < free_c[i]));
        chk($sformatf("resp_valid[%0d]", i), 32'(rv[i]), 32'(cyc == res_c[i]));
        if (cyc == res_c[i]) begin
          chk($sformatf("resp_rdata[%0d]", i), rd[i], exp_rd[i]);
          chk($sformatf("resp_err[%0d]", i), 32'(re[i]), 32'(exp_er[i]));
        end
      end
  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output int acc);
    for (int k = 0; k < 40 && !(rdy[0] && rdy[1]); k++) @(negedge clk);
    if (!(rdy[0] && rdy[1])) chk("idle_timeout", 32'd0, 32'd1);
    req_wr = wr;
    req_addr = a;
    req_be = be;
    req_wdata = wd;
    req_valid = 1;
    acc = cyc;
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic wait_resp(input int i, output int rc, output logic [31:0] d, output logic e);
    rc = -1;
    d = 32'hx;
    e = 1'bx;
    for (int k = 0; k < 40 && rc < 0; k++)
      if (rv[i]) begin
        rc = cyc;
        d = rd[i];
        e = re[i];
      end else @(negedge clk);
    if (rc < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output int l, output logic [31:0] d, output logic e);
    int acc, rc;
    issue(wr, a, be, wd, acc);
    wait_resp(0, rc, d, e);
    l = rc - acc;
  endtask
  int          acc, l, n, nr;
  logic [31:0] d;
  logic        e;
  bit          acc_now;
  logic [31:0] t3_d[4] = '{32'h0000AB00, 32'hCAFE0000, 32'h0000BEEF, 32'hFFFFFFFF};
  logic [3:0]  t3_b[4] = '{4'b0010, BE_HALF_HI, BE_HALF_LO, 4'b0000};
  logic [31:0] t3_e[4] = '{32'h1234AB78, 32'hCAFEAB78, 32'hCAFEBEEF, 32'hCAFEBEEF};
  logic [31:0] a5[3] = '{32'h20, 32'h10, 32'h0};
  logic [31:0] e5[3] = '{32'hCAFEBEEF, 32'hDEADBEEF, 32'hA5A5A5A5};
  int          ac5[3] = '{-100, -100, -100};
  int          rc5[3] = '{-50, -50, -50};
  logic [31:0] rd5[3];
  initial begin
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_resp_valid", 32'(rv[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'd0);
    chk("rst_err", 32'(re[0]), 32'd0);
    reset = 0;
    started = 1;
    @(negedge clk);
    xfer(1, 32'h10, BE_WORD, 32'h0, l, d, e);
    xfer(1, 32'h0, BE_WORD, 32'hA5A5A5A5, l, d, e);
    // reset while the LATENCY=2 responder sits in WAIT drops the store
    issue(1, 32'h10, BE_WORD, 32'hDEADBEEF, acc);
    #2 reset = 1;
    @(negedge clk);
    chk("t1_rst_resp_valid", 32'(rv[0]), 32'd0);
    chk("t1_rst_busy", 32'(bsy[0]), 32'd0);
    chk("t1_rst_ready", 32'(rdy[0]), 32'd1);
    reset = 0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(rv[0]);
    end
    chk("t1_no_resp", 32'(n), 32'd0);
    xfer(0, 32'h10, BE_WORD, 32'h0, l, d, e);
    chk("t1_load", d, 32'h0);
    xfer(1, 32'h20, BE_WORD, 32'h12345678, l, d, e);
    chk("t2_store_lat", 32'(l), 32'd3);
    chk("t2_store_rdata", d, 32'h0);
    xfer(0, 32'h20, BE_WORD, 32'h0, l, d, e);
    chk("t2_load_lat", 32'(l), 32'd3);
    chk("t2_load_rdata", d, 32'h12345678);
    chk("t2_load_err", 32'(e), 32'd0);
    for (int j = 0; j < 4; j++) begin
      xfer(1, 32'h20, t3_b[j], t3_d[j], l, d, e);
      xfer(0, 32'h20, BE_WORD, 32'h0, l, d, e);
      chk($sformatf("t3_partial[%0d]", j), d, t3_e[j]);
    end
    xfer(1, 32'h1000, BE_WORD, 32'hFFFFFFFF, l, d, e);
    chk("t4_store_err", 32'(e), 32'd1);
    chk("t4_store_rdata", d, 32'h0);
    xfer(0, 32'h1000, BE_WORD, 32'h0, l, d, e);
    chk("t4_load_err", 32'(e), 32'd1);
    chk("t4_load_rdata", d, 32'h0);
    xfer(0, 32'h0, BE_WORD, 32'h0, l, d, e);
    chk("t4_word0", d, 32'hA5A5A5A5);
    chk("t4_word0_err", 32'(e), 32'd0);
    // zero-latency responder with req_valid held across three loads
    for (int k = 0; k < 40 && !(rdy[0] && rdy[1]); k++) @(negedge clk);
    n = 0;
    nr = 0;
    req_wr = 0;
    req_be = BE_WORD;
    req_addr = a5[0];
    req_valid = 1;
    for (int k = 0; k < 20 && nr < 3; k++) begin
      if (rv[1]) begin
        rc5[nr] = cyc;
        rd5[nr] = rd[1];
        nr++;
      end
      acc_now = rdy[1] && n < 3;
      if (acc_now) begin
        ac5[n] = cyc;
        n++;
      end
      @(negedge clk);
      if (acc_now) begin
        if (n < 3) req_addr = a5[n];
        else req_valid = 0;
      end
    end
    req_valid = 0;
    chk("t5_spacing01", 32'(ac5[1] - ac5[0]), 32'd2);
    chk("t5_spacing12", 32'(ac5[2] - ac5[1]), 32'd2);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("t5_lat[%0d]", j), 32'(rc5[j] - ac5[j]), 32'd1);
      chk($sformatf("t5_rdata[%0d]", j), rd5[j], e5[j]);
    end
    // inputs wiggle while the LATENCY=2 responder waits
    issue(1, 32'h30, BE_WORD, 32'h55667788, acc);
    req_addr = 32'h34;
    req_wdata = 32'hFFFFFFFF;
    chk("t6_ready_w1", 32'(rdy[0]), 32'd0);
    chk("t6_busy_w1", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    req_valid = 1;
    chk("t6_ready_w2", 32'(rdy[0]), 32'd0);
    chk("t6_busy_w2", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    req_valid = 0;
    chk("t6_resp_valid", 32'(rv[0]), 32'd1);
    chk("t6_busy_resp", 32'(bsy[0]), 32'd1);
    chk("t6_resp_rdata", rd[0], 32'h0);
    @(negedge clk);
    chk("t6_busy_idle", 32'(bsy[0]), 32'd0);
    chk("t6_ready_idle", 32'(rdy[0]), 32'd1);
    xfer(0, 32'h30, BE_WORD, 32'h0, l, d, e);
    chk("t6_load", d, 32'h55667788);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
